// File: rtl/note_sequencer.sv
// Melody player: steps a fixed 16-entry note ROM and times each note and its gap from a 1 ms tick.
// Latency: a play/stop edge or a note boundary reaches the outputs 1 cycle later, because all outputs are registered.
// Backpressure: none; play and stop are edge events, and loop is a level sampled only when the song advances.
module note_sequencer #(
  parameter int TICK_DIV = 100000,
  parameter int UNIT_MS  = 50,
  parameter int GAP_MS   = 10,
  parameter int SONG_LEN = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        play,
  input  logic        stop,
  input  logic        loop,
  output logic [11:0] freq,
  output logic        tone_en,
  output logic        busy,
  output logic [3:0]  note_idx
);

  localparam int PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MS_MAX = (15 * UNIT_MS > GAP_MS) ? 15 * UNIT_MS : GAP_MS;
  localparam int MW     = $clog2(MS_MAX + 1);

  localparam logic [PW-1:0] PRESC_TC = PW'(TICK_DIV - 1);
  localparam logic [3:0]    LAST_IDX = 4'(SONG_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NOTE = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ACT_RUN   = 2'd0,
    ACT_CLEAR = 2'd1,
    ACT_LOAD  = 2'd2,
    ACT_GAP   = 2'd3
  } act_t;

  state_t          state;
  state_t          state_nxt;
  act_t            act;
  logic [3:0]      load_idx;
  logic [7:0]      load_entry;
  logic [7:0]      next_entry;
  logic [3:0]      next_idx;

  logic            play_q;
  logic            stop_q;
  logic            play_rise;
  logic            stop_rise;

  logic [PW-1:0]   presc;
  logic [MW-1:0]   ms_cnt;
  logic            tick;
  logic            ms_done;
  logic            song_end;

  logic [PW-1:0]   presc_nxt;
  logic [MW-1:0]   ms_nxt;
  logic [11:0]     freq_nxt;
  logic            tone_nxt;
  logic [3:0]      idx_nxt;

  // Each entry is {code, dur}; dur 0 marks the end of the song.
  function automatic logic [7:0] rom_byte(input logic [3:0] idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = 8'h02;
      4'd1:    b = 8'h22;
      4'd2:    b = 8'h42;
      4'd3:    b = 8'h52;
      4'd4:    b = 8'h74;
      4'd5:    b = 8'h92;
      4'd6:    b = 8'hB2;
      4'd7:    b = 8'hF2;
      4'd8:    b = 8'hB2;
      4'd9:    b = 8'h92;
      4'd10:   b = 8'h74;
      4'd11:   b = 8'h42;
      4'd12:   b = 8'h08;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Codes 12..15 are all silent rests.
  function automatic logic [11:0] code_freq(input logic [3:0] code);
    logic [11:0] f;
    case (code)
      4'd0:    f = 12'd261;
      4'd1:    f = 12'd277;
      4'd2:    f = 12'd293;
      4'd3:    f = 12'd311;
      4'd4:    f = 12'd330;
      4'd5:    f = 12'd349;
      4'd6:    f = 12'd370;
      4'd7:    f = 12'd392;
      4'd8:    f = 12'd415;
      4'd9:    f = 12'd440;
      4'd10:   f = 12'd466;
      4'd11:   f = 12'd494;
      default: f = 12'd0;
    endcase
    return f;
  endfunction

  assign play_rise  = play & ~play_q;
  assign stop_rise  = stop & ~stop_q;
  assign tick       = (presc == PRESC_TC);
  assign ms_done    = tick && (ms_cnt == MW'(1));
  assign next_idx   = note_idx + 4'd1;
  assign next_entry = rom_byte(next_idx);
  assign song_end   = (note_idx == LAST_IDX) || (next_entry[3:0] == 4'd0);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      play_q <= 1'b0;
      stop_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      play_q <= play;
      stop_q <= stop;
    end
  end

  // Stop beats play; play beats the normal timing path; a load of a dur-0 entry collapses to IDLE.
  always_comb begin
    state_nxt  = state;
    act        = ACT_RUN;
    load_idx   = 4'd0;
    load_entry = 8'h00;
    if (stop_rise) begin
      state_nxt = IDLE;
      act       = ACT_CLEAR;
    end else if (play_rise) begin
      act      = ACT_LOAD;
      load_idx = 4'd0;
    end else if (state != IDLE && ms_done) begin
      if (state == NOTE && GAP_MS > 0) begin
        state_nxt = GAP;
        act       = ACT_GAP;
      end else if (song_end) begin
        if (loop) begin
          act      = ACT_LOAD;
          load_idx = 4'd0;
        end else begin
          state_nxt = IDLE;
          act       = ACT_CLEAR;
        end
      end else begin
        act      = ACT_LOAD;
        load_idx = next_idx;
      end
    end
    if (act == ACT_LOAD) begin
      load_entry = rom_byte(load_idx);
      if (load_entry[3:0] == 4'd0) begin
        state_nxt = IDLE;
        act       = ACT_CLEAR;
      end else begin
        state_nxt = NOTE;
      end
    end
  end

  always_comb begin
    presc_nxt = presc;
    ms_nxt    = ms_cnt;
    freq_nxt  = freq;
    tone_nxt  = tone_en;
    idx_nxt   = note_idx;
    case (act)
      ACT_CLEAR: begin
        presc_nxt = '0;
        ms_nxt    = '0;
        freq_nxt  = 12'd0;
        tone_nxt  = 1'b0;
        idx_nxt   = 4'd0;
      end
      ACT_LOAD: begin
        presc_nxt = '0;
        ms_nxt    = MW'(int'(load_entry[3:0]) * UNIT_MS);
        freq_nxt  = code_freq(load_entry[7:4]);
        tone_nxt  = (load_entry[7:4] < 4'd12);
        idx_nxt   = load_idx;
      end
      ACT_GAP: begin
        presc_nxt = '0;
        ms_nxt    = MW'(GAP_MS);
        freq_nxt  = 12'd0;
        tone_nxt  = 1'b0;
      end
      default: begin
        if (state != IDLE) begin
          presc_nxt = tick ? '0 : presc + PW'(1);
          ms_nxt    = tick ? ms_cnt - MW'(1) : ms_cnt;
        end else begin
          presc_nxt = '0;
          ms_nxt    = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc    <= '0;
      ms_cnt   <= '0;
      freq     <= 12'd0;
      tone_en  <= 1'b0;
      note_idx <= 4'd0;
    end else begin
      presc    <= presc_nxt;
      ms_cnt   <= ms_nxt;
      freq     <= freq_nxt;
      tone_en  <= tone_nxt;
      note_idx <= idx_nxt;
    end
  end

endmodule
